tnn_column: RTL and testbench

//  Parametrised successor of the fixed-size spiking layer: NUM_NEURONS integrate-and-fire neurons over NUM_INPUTS time-coded inputs.
//  - Consumes one input volley per valid/ready handshake.
//  - Runs one gamma cycle of 2**TBITS steps, then applies 1-winner-take-all lateral inhibition.
//  - When training, applies saturating STDP, sequenced one neuron per cycle.
//  - Returns the winner and its spike time on a valid/ready output. Instances chain column to column.

---
 rtl/tnn_pkg.sv | 45 ++++
 rtl/tnn_column_if.sv | 41 ++++
 rtl/tnn_neuron.sv | 53 +++++
 rtl/tnn_column.sv | 209 ++++++++++++++++++++
 tb/tb_tnn_column.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tnn_pkg.sv
// tnn_pkg: shared state type and helpers for the temporal neural column.
// A time code is a TBITS value with a no-spike flag at bit TBITS.
package tnn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STDP,
      DONE
   } state_t;

   localparam int TC_W = 16;

   function automatic logic no_spike(
      input logic [TC_W-1:0] tc,
      input int tbits
   );
      logic [TC_W-1:0] s;
      s = tc >> tbits;
      return s[0];
   endfunction

   function automatic logic [TC_W-1:0] tval(
      input logic [TC_W-1:0] tc,
      input int tbits
   );
      return tc & ((TC_W'(1) << tbits) - TC_W'(1));
   endfunction

   function automatic int sat_add(
      input int w,
      input int mu,
      input int wmax
   );
      return (w + mu > wmax) ? wmax : w + mu;
   endfunction

   function automatic int sat_sub(
      input int w,
      input int mu
   );
      return (w - mu < 0) ? 0 : w - mu;
   endfunction

endpackage

// File: rtl/tnn_column_if.sv
// tnn_column_if: volley input and winner output handshakes of a column.
// master drives volleys and consumes results; slave is the column.
interface tnn_column_if #(
   parameter int NUM_INPUTS  = 16,
   parameter int NUM_NEURONS = 8,
   parameter int TBITS       = 3
);
   localparam int WIDX = $clog2(NUM_NEURONS) + 1;

   logic                           training;
   logic                           in_valid;
   logic                           in_ready;
   logic [NUM_INPUTS-1:0][TBITS:0] in_times;
   logic                           out_valid;
   logic                           out_ready;
   logic [TBITS:0]                 out_time;
   logic [WIDX-1:0]                out_winner;

   modport master (
      output training,
      output in_valid,
      output in_times,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_time,
      input  out_winner
   );

   modport slave (
      input  training,
      input  in_valid,
      input  in_times,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_time,
      output out_winner
   );

endinterface

// File: rtl/tnn_neuron.sv
// tnn_neuron: integrate-and-fire neuron over an active-input mask.
// fire_now pulses on the step the potential first reaches threshold.
module tnn_neuron #(
   parameter int NUM_INPUTS = 16,
   parameter int WBITS      = 3,
   parameter int PBITS      = 10,
   parameter int THRESH     = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clear,
   input  logic                             step,
   input  logic [NUM_INPUTS-1:0]            active,
   input  logic [NUM_INPUTS-1:0][WBITS-1:0] w,
   output logic                             fired,
   output logic                             fire_now
);

   logic [PBITS-1:0] pot_q;
   logic [PBITS-1:0] sum;
   logic [PBITS-1:0] pot_d;
   logic             fired_q;

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (active[i]) begin
            sum = sum + PBITS'(w[i]);
         end
      end
   end

   assign pot_d    = pot_q + sum;
   assign fire_now = step && !fired_q &&
                     (pot_d >= PBITS'(THRESH));
   assign fired    = fired_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pot_q   <= '0;
         fired_q <= 1'b0;
      end else if (clear) begin
         pot_q   <= '0;
         fired_q <= 1'b0;
      end else if (step) begin
         pot_q <= pot_d;
         if (fire_now) begin
            fired_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/tnn_column.sv
// tnn_column: column of integrate-and-fire neurons with 1-WTA
// inhibition and saturating STDP applied one neuron per cycle.
import tnn_pkg::*;

module tnn_column #(
   parameter int NUM_INPUTS  = 16,
   parameter int NUM_NEURONS = 8,
   parameter int WBITS       = 3,
   parameter int TBITS       = 3,
   parameter int THRESH      = 8,
   parameter int WINIT       = 1,
   parameter int MU_CAPTURE  = 2,
   parameter int MU_BACKOFF  = 1,
   parameter int MU_SEARCH   = 1
) (
   input logic         clk,
   input logic         rst,
   tnn_column_if.slave bus
);

   localparam int WMAX  = 2**WBITS - 1;
   localparam int T     = 2**TBITS;
   localparam int WIDX  = $clog2(NUM_NEURONS) + 1;
   localparam int IBITS = (NUM_NEURONS > 1) ?
                          $clog2(NUM_NEURONS) : 1;
   localparam int PBITS = WBITS + $clog2(NUM_INPUTS) + TBITS;

   typedef logic [NUM_INPUTS-1:0][WBITS-1:0] row_t;
   typedef logic [NUM_INPUTS-1:0][TBITS:0]   times_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [TBITS-1:0]       t_q;
   logic [IBITS-1:0]       idx_q;
   times_t                 times_q;
   logic                   train_q;
   logic                   has_win_q;
   logic [WIDX-1:0]        win_q;
   logic [TBITS-1:0]       wtime_q;
   logic                   out_valid_q;
   logic [TBITS:0]         out_time_q;
   logic [WIDX-1:0]        out_winner_q;
   row_t [NUM_NEURONS-1:0] w_q;

   logic                   accept;
   logic                   step;
   logic                   t_last;
   logic                   idx_last;
   logic                   is_win;
   logic [NUM_INPUTS-1:0]  spiked;
   logic [NUM_INPUTS-1:0]  early;
   logic [NUM_INPUTS-1:0]  active;
   logic [NUM_NEURONS-1:0] fired;
   logic [NUM_NEURONS-1:0] fire_now;
   logic [WIDX-1:0]        first;
   row_t                   row_d;
   int                     wi;

   assign accept   = (state_q == IDLE) && bus.in_valid;
   assign step     = (state_q == RUN);
   assign t_last   = (t_q == TBITS'(T - 1));
   assign idx_last = (idx_q == IBITS'(NUM_NEURONS - 1));

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = out_valid_q;
   assign bus.out_time   = out_time_q;
   assign bus.out_winner = out_winner_q;

   always_comb begin
      spiked = '0;
      early  = '0;
      active = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         spiked[i] = !no_spike(TC_W'(times_q[i]), TBITS);
         early[i]  = tval(TC_W'(times_q[i]), TBITS) <=
                     TC_W'(wtime_q);
         active[i] = step && spiked[i] &&
                     (tval(TC_W'(times_q[i]), TBITS) <=
                      TC_W'(t_q));
      end
   end

   for (genvar j = 0; j < NUM_NEURONS; j++) begin : g_neuron
      tnn_neuron #(
         .NUM_INPUTS (NUM_INPUTS),
         .WBITS      (WBITS),
         .PBITS      (PBITS),
         .THRESH     (THRESH)
      ) u_neuron (
         .clk      (clk),
         .rst      (rst),
         .clear    (accept),
         .step     (step),
         .active   (active),
         .w        (w_q[j]),
         .fired    (fired[j]),
         .fire_now (fire_now[j])
      );
   end

   // Lowest index wins ties within a step.
   always_comb begin
      first = '1;
      for (int j = NUM_NEURONS - 1; j >= 0; j--) begin
         if (fire_now[j]) begin
            first = WIDX'(j);
         end
      end
   end

   always_comb begin
      row_d  = w_q[idx_q];
      wi     = 0;
      is_win = has_win_q && (win_q == WIDX'(idx_q));
      for (int i = 0; i < NUM_INPUTS; i++) begin
         wi = int'(w_q[idx_q][i]);
         if (is_win) begin
            if (spiked[i] && early[i]) begin
               row_d[i] = WBITS'(sat_add(wi, MU_CAPTURE, WMAX));
            end else begin
               row_d[i] = WBITS'(sat_sub(wi, MU_BACKOFF));
            end
         end else if (fired[idx_q]) begin
            if (spiked[i]) begin
               row_d[i] = WBITS'(sat_sub(wi, MU_BACKOFF));
            end
         end else if (spiked[i]) begin
            row_d[i] = WBITS'(sat_add(wi, MU_SEARCH, WMAX));
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = RUN;
         RUN: begin
            if (t_last) state_d = train_q ? STDP : DONE;
         end
         STDP: if (idx_last) state_d = DONE;
         DONE: begin
            if (out_valid_q && bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t_q          <= '0;
         idx_q        <= '0;
         times_q      <= '1;
         train_q      <= 1'b0;
         has_win_q    <= 1'b0;
         win_q        <= '1;
         wtime_q      <= '0;
         out_valid_q  <= 1'b0;
         out_time_q   <= '1;
         out_winner_q <= '1;
         w_q <= {(NUM_NEURONS * NUM_INPUTS){WBITS'(WINIT)}};
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  times_q   <= bus.in_times;
                  train_q   <= bus.training;
                  t_q       <= '0;
                  idx_q     <= '0;
                  has_win_q <= 1'b0;
                  win_q     <= '1;
                  wtime_q   <= '0;
               end
            end
            RUN: begin
               if (!t_last) t_q <= t_q + TBITS'(1);
               if (!has_win_q && (|fire_now)) begin
                  has_win_q <= 1'b1;
                  win_q     <= first;
                  wtime_q   <= t_q;
               end
            end
            STDP: begin
               w_q[idx_q] <= row_d;
               if (!idx_last) idx_q <= idx_q + IBITS'(1);
            end
            DONE: begin
               if (!out_valid_q) begin
                  out_valid_q  <= 1'b1;
                  out_winner_q <= win_q;
                  out_time_q   <= has_win_q ?
                                  {1'b0, wtime_q} : '1;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tnn_column.sv
// tb_tnn_column: directed vector table, hold/reset sequences and
// random volleys against a closed-form model of the column.
`timescale 1ns/1ps
module tb_tnn_column;

   localparam int NI   = 16;
   localparam int NN   = 8;
   localparam int TB   = 3;
   localparam int TH   = 8;
   localparam int WI   = 1;
   localparam int T    = 8;
   localparam int WMAX = 7;

   typedef logic [NI-1:0][TB:0] times_t;
   typedef struct {
      times_t     tm;
      logic [3:0] ewin;
      logic [3:0] etime;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tnn_column_if #(
      .NUM_INPUTS  (NI),
      .NUM_NEURONS (NN),
      .TBITS       (TB)
   ) bus ();

   tnn_column #(
      .NUM_INPUTS  (NI),
      .NUM_NEURONS (NN),
      .WBITS       (3),
      .TBITS       (TB),
      .THRESH      (TH),
      .WINIT       (WI),
      .MU_CAPTURE  (2),
      .MU_BACKOFF  (1),
      .MU_SEARCH   (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int mw [NN][NI];

   task automatic check(input string nm, input int got,
                        input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   function automatic times_t mk(input int lo, input int hi,
                                 input int t);
      times_t r;
      for (int i = 0; i < NI; i++) begin
         r[i] = (i >= lo && i <= hi) ? 4'(t) : 4'b1000;
      end
      return r;
   endfunction

   // Potential at step t is sum of w * (t - time + 1) over spiked inputs.
   task automatic model(input times_t tm, input bit tr,
                        output int ew, output int et);
      int ft [NN];
      int pot;
      int tv;
      int best;
      bit sp;
      ew   = 15;
      et   = 15;
      best = T;
      for (int j = 0; j < NN; j++) begin
         ft[j] = -1;
         for (int t = 0; t < T; t++) begin
            pot = 0;
            for (int i = 0; i < NI; i++) begin
               tv = int'(tm[i][TB-1:0]);
               if (!tm[i][TB] && tv <= t)
                  pot += mw[j][i] * (t - tv + 1);
            end
            if (ft[j] < 0 && pot >= TH) ft[j] = t;
         end
         if (ft[j] >= 0 && ft[j] < best) begin
            best = ft[j];
            ew   = j;
            et   = ft[j];
         end
      end
      if (tr) begin
         for (int j = 0; j < NN; j++) begin
            for (int i = 0; i < NI; i++) begin
               sp = !tm[i][TB];
               tv = int'(tm[i][TB-1:0]);
               if (ew == j) begin
                  if (sp && tv <= et)
                     mw[j][i] = (mw[j][i] + 2 > WMAX) ? WMAX : mw[j][i] + 2;
                  else
                     mw[j][i] = (mw[j][i] > 0) ? mw[j][i] - 1 : 0;
               end else if (ft[j] >= 0) begin
                  if (sp) mw[j][i] = (mw[j][i] > 0) ? mw[j][i] - 1 : 0;
               end else if (sp) begin
                  mw[j][i] = (mw[j][i] < WMAX) ? mw[j][i] + 1 : WMAX;
               end
            end
         end
      end
   endtask

   task automatic check_weights(input string nm);
      int bad;
      bad = 0;
      for (int j = 0; j < NN; j++)
         for (int i = 0; i < NI; i++)
            if (int'(dut.w_q[j][i]) != mw[j][i]) bad++;
      check(nm, bad, 0);
   endtask

   // Training is flipped right after accept; it must not affect the volley.
   task automatic volley(input times_t tm, input bit tr,
                         input int hold, input int ew, input int et);
      int cnt;
      check("in_ready_idle", int'(bus.in_ready), 1);
      bus.in_times = tm;
      bus.training = tr;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.training = !tr;
      cnt = 0;
      while (!bus.out_valid && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("latency", cnt, tr ? T + NN + 1 : T + 1);
      check("out_winner", int'(bus.out_winner), ew);
      check("out_time", int'(bus.out_time), et);
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = h[0];
         bus.in_times = ~tm;
         @(posedge clk); #1;
         check("hold_valid", int'(bus.out_valid), 1);
         check("hold_winner", int'(bus.out_winner), ew);
         check("hold_time", int'(bus.out_time), et);
         check("hold_in_ready", int'(bus.in_ready), 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("out_valid_drop", int'(bus.out_valid), 0);
      check("winner_kept", int'(bus.out_winner), ew);
   endtask

   task automatic mvolley(input times_t tm, input bit tr,
                          input int hold);
      int ew;
      int et;
      model(tm, tr, ew, et);
      volley(tm, tr, hold, ew, et);
      check_weights("weights");
   endtask

   initial begin
      vec_t   tbl [6];
      times_t tm;
      int     r;

      bus.in_valid  = 1'b0;
      bus.training  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_times  = '1;
      for (int j = 0; j < NN; j++)
         for (int i = 0; i < NI; i++) mw[j][i] = WI;

      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_time", int'(bus.out_time), 15);
      check("rst_out_winner", int'(bus.out_winner), 15);
      check_weights("rst_weights");

      tbl[0] = '{mk(0, 15, 0), 4'd0, 4'd0};
      tbl[1] = '{mk(0, -1, 0), 4'hF, 4'hF};
      tbl[2] = '{mk(0, 15, 3), 4'd0, 4'd3};
      tbl[3] = '{mk(0, 3, 0), 4'd0, 4'd1};
      tbl[4] = '{mk(5, 5, 0), 4'd0, 4'd7};
      tbl[5] = '{mk(5, 5, 1), 4'hF, 4'hF};
      for (int k = 0; k < 6; k++) begin
         volley(tbl[k].tm, 1'b0, 0, int'(tbl[k].ewin),
                int'(tbl[k].etime));
      end

      volley(mk(0, -1, 0), 1'b1, 0, 15, 15);
      check_weights("silent_train_w");

      mvolley(mk(0, 3, 0), 1'b1, 0);
      check("w0_causal", int'(dut.w_q[0][0]), 3);
      check("w0_other", int'(dut.w_q[0][4]), 0);
      check("w1_causal", int'(dut.w_q[1][0]), 0);
      check("w1_other", int'(dut.w_q[1][4]), 1);
      repeat (5) mvolley(mk(0, 3, 0), 1'b1, 0);
      check("w0_sat", int'(dut.w_q[0][3]), 7);
      check("w0_floor", int'(dut.w_q[0][9]), 0);

      mvolley(mk(0, 15, 2), 1'b0, 5);

      bus.in_times = mk(0, 15, 0);
      bus.training = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_in_ready", int'(bus.in_ready), 1);
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_winner", int'(bus.out_winner), 15);
      for (int j = 0; j < NN; j++)
         for (int i = 0; i < NI; i++) mw[j][i] = WI;
      check_weights("midrst_weights");
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      volley(mk(0, 7, 1), 1'b0, 0, 0, 1);

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NI; i++) begin
            r = int'($urandom_range(0, 3));
            tm[i] = (r == 0) ? 4'b1000 : 4'($urandom_range(0, 7));
         end
         mvolley(tm, 1'($urandom_range(0, 1)), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
